// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: tag/data words, the "value present" tag and the issue record.
package tomasulo_pkg;

    localparam int TAG_W_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;

    typedef logic [TAG_W_DEF-1:0]  tag_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

    localparam tag_t TAG_NONE = {TAG_W_DEF{1'b0}};

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_MEM = 2'd3
    } e_functional_unit;

    typedef struct packed {
        logic [OP_W_DEF-1:0] op;
        data_t               vj;
        tag_t                qj;
        data_t               vk;
        tag_t                qk;
    } rs_issue_t;

endpackage

// File: rtl/reservation_station_bank_if.sv
// Issue, CDB and dispatch signals of one reservation-station bank.
interface reservation_station_bank_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 4,
    parameter int ENTRIES = 4
);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [TAG_W-1:0]  issue_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic [TAG_W-1:0]  disp_tag;

    logic [CNT_W-1:0]  busy_count;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data, disp_ready,
        input  issue_ready, issue_tag, disp_valid, disp_op, disp_vj, disp_vk,
        input  disp_tag, busy_count
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data, disp_ready,
        output issue_ready, issue_tag, disp_valid, disp_op, disp_vj, disp_vk,
        output disp_tag, busy_count
    );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station entry: operand storage, CDB snoop (including issue bypass) and ready flag.
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [DATA_W-1:0] alloc_vj,
    input  logic [TAG_W-1:0]  alloc_qj,
    input  logic [DATA_W-1:0] alloc_vk,
    input  logic [TAG_W-1:0]  alloc_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              retire,
    output logic              busy,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);

    localparam logic [TAG_W-1:0] TAG_NONE_W = TAG_W'(TAG_NONE);

    logic              busy_r;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] vj_r;
    logic [DATA_W-1:0] vk_r;
    logic [TAG_W-1:0]  qj_r;
    logic [TAG_W-1:0]  qk_r;
    logic              hit_j_s;
    logic              hit_k_s;

    function automatic logic tag_hit(input logic v, input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] q);
        return v && (bus_tag != TAG_NONE_W) && (bus_tag == q);
    endfunction

    // Snoop against the incoming tags while allocating, otherwise against the stored ones.
    always_comb begin
        hit_j_s = tag_hit(cdb_valid, cdb_tag, alloc ? alloc_qj : qj_r);
        hit_k_s = tag_hit(cdb_valid, cdb_tag, alloc ? alloc_qk : qk_r);
    end

    // Entry storage: allocation, operand capture and release on dispatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            op_r   <= {OP_W{1'b0}};
            vj_r   <= {DATA_W{1'b0}};
            vk_r   <= {DATA_W{1'b0}};
            qj_r   <= TAG_NONE_W;
            qk_r   <= TAG_NONE_W;
        end else if (alloc) begin
            busy_r <= 1'b1;
            op_r   <= alloc_op;
            vj_r   <= hit_j_s ? cdb_data : alloc_vj;
            qj_r   <= hit_j_s ? TAG_NONE_W : alloc_qj;
            vk_r   <= hit_k_s ? cdb_data : alloc_vk;
            qk_r   <= hit_k_s ? TAG_NONE_W : alloc_qk;
        end else begin
            busy_r <= busy_r & ~retire;
            if (busy_r && hit_j_s) begin
                vj_r <= cdb_data;
                qj_r <= TAG_NONE_W;
            end
            if (busy_r && hit_k_s) begin
                vk_r <= cdb_data;
                qk_r <= TAG_NONE_W;
            end
        end
    end

    assign busy  = busy_r;
    assign ready = busy_r && (qj_r == TAG_NONE_W) && (qk_r == TAG_NONE_W);
    assign op    = op_r;
    assign vj    = vj_r;
    assign vk    = vk_r;

endmodule

// File: rtl/reservation_station_bank.sv
// Reservation-station bank: lowest-free allocator, age matrix, oldest-ready select and locked dispatch offer.
module reservation_station_bank
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES  = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 4,
    parameter int TAG_BASE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    reservation_station_bank_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam logic [TAG_W-1:0] TAG_BASE_T = TAG_W'(TAG_BASE);

    logic [ENTRIES-1:0] busy_s;
    logic [ENTRIES-1:0] ready_s;
    logic [ENTRIES-1:0] alloc_s;
    logic [ENTRIES-1:0] retire_s;
    logic [ENTRIES-1:0] has_older_s;
    logic [OP_W-1:0]    ent_op_s [ENTRIES];
    logic [DATA_W-1:0]  ent_vj_s [ENTRIES];
    logic [DATA_W-1:0]  ent_vk_s [ENTRIES];

    logic [ENTRIES-1:0] age_r [ENTRIES];
    logic               lock_r;
    logic [IDX_W-1:0]   lock_idx_r;

    logic [IDX_W-1:0]   alloc_idx_s;
    logic [IDX_W-1:0]   oldest_idx_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               issue_ready_s;
    logic               accept_s;
    logic               disp_valid_s;
    logic               disp_fire_s;
    logic [CNT_W-1:0]   count_s;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        rs_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .OP_W   (OP_W)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .alloc     (alloc_s[g]),
            .alloc_op  (bus.issue_op),
            .alloc_vj  (bus.issue_vj),
            .alloc_qj  (bus.issue_qj),
            .alloc_vk  (bus.issue_vk),
            .alloc_qk  (bus.issue_qk),
            .cdb_valid (bus.cdb_valid),
            .cdb_tag   (bus.cdb_tag),
            .cdb_data  (bus.cdb_data),
            .retire    (retire_s[g]),
            .busy      (busy_s[g]),
            .ready     (ready_s[g]),
            .op        (ent_op_s[g]),
            .vj        (ent_vj_s[g]),
            .vk        (ent_vk_s[g])
        );
    end

    // Lowest-index free entry and occupancy count.
    always_comb begin
        alloc_idx_s = {IDX_W{1'b0}};
        count_s     = {CNT_W{1'b0}};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            alloc_idx_s = busy_s[i] ? alloc_idx_s : IDX_W'(i);
            count_s     = count_s + CNT_W'(busy_s[i]);
        end
    end

    // An entry is oldest-ready when no other ready entry is older than it (age_r[j][i]: j older than i).
    always_comb begin
        has_older_s  = {ENTRIES{1'b0}};
        oldest_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                has_older_s[i] = has_older_s[i] | (ready_s[j] & age_r[j][i]);
            end
            oldest_idx_s = (ready_s[i] && !has_older_s[i]) ? IDX_W'(i) : oldest_idx_s;
        end
    end

    // Handshake decode; a locked offer keeps its entry regardless of newly ready older ones.
    always_comb begin
        issue_ready_s = ~&busy_s;
        accept_s      = bus.issue_valid && issue_ready_s;
        disp_valid_s  = lock_r || (|ready_s);
        sel_idx_s     = lock_r ? lock_idx_r : oldest_idx_s;
        disp_fire_s   = disp_valid_s && bus.disp_ready;
        for (int i = 0; i < ENTRIES; i++) begin
            alloc_s[i]  = accept_s && (alloc_idx_s == IDX_W'(i));
            retire_s[i] = disp_fire_s && (sel_idx_s == IDX_W'(i));
        end
    end

    // Newly issued entry becomes younger than every other entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age_r[i] <= {ENTRIES{1'b0}};
            end
        end else if (accept_s) begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (IDX_W'(i) == alloc_idx_s) begin
                        age_r[i][j] <= 1'b0;
                    end else if (IDX_W'(j) == alloc_idx_s) begin
                        age_r[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Offer lock: held while the functional unit stalls an offered operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r     <= 1'b0;
            lock_idx_r <= {IDX_W{1'b0}};
        end else if (disp_valid_s && !bus.disp_ready) begin
            lock_r     <= 1'b1;
            lock_idx_r <= sel_idx_s;
        end else begin
            lock_r     <= 1'b0;
        end
    end

    assign bus.issue_ready = issue_ready_s;
    assign bus.issue_tag   = TAG_BASE_T + TAG_W'(alloc_idx_s);
    assign bus.busy_count  = count_s;
    assign bus.disp_valid  = disp_valid_s;
    assign bus.disp_op     = disp_valid_s ? ent_op_s[sel_idx_s] : {OP_W{1'b0}};
    assign bus.disp_vj     = disp_valid_s ? ent_vj_s[sel_idx_s] : {DATA_W{1'b0}};
    assign bus.disp_vk     = disp_valid_s ? ent_vk_s[sel_idx_s] : {DATA_W{1'b0}};
    assign bus.disp_tag    = disp_valid_s ? (TAG_BASE_T + TAG_W'(sel_idx_s)) : {TAG_W{1'b0}};

endmodule

// File: tb/tb_reservation_station_bank.sv
// Directed self-checking bench for reservation_station_bank (4 entries, tags 1..4).
module tb_reservation_station_bank;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reservation_station_bank_if #(.DATA_W(32), .TAG_W(4), .OP_W(4), .ENTRIES(4)) bus ();

    reservation_station_bank #(
        .ENTRIES(4), .DATA_W(32), .TAG_W(4), .OP_W(4), .TAG_BASE(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_op    = 4'd0;
        bus.issue_vj    = 32'd0;
        bus.issue_vk    = 32'd0;
        bus.issue_qj    = 4'd0;
        bus.issue_qk    = 4'd0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = 4'd0;
        bus.cdb_data    = 32'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj,
                         input logic [31:0] vk, input logic [3:0] qk);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_vj    = vj;
        bus.issue_qj    = qj;
        bus.issue_vk    = vk;
        bus.issue_qk    = qk;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.disp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b want 1", bus.issue_ready); end
        n_checks++; if (bus.issue_tag !== 4'd1) begin n_fail++; $display("FAIL reset_issue_tag: got %0d want 1", bus.issue_tag); end
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid: got %b want 0", bus.disp_valid); end
        n_checks++; if ({bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag} !== 72'd0) begin n_fail++; $display("FAIL reset_disp_fields: got op=%0d vj=%h vk=%h tag=%0d want zeros", bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag); end
        n_checks++; if (bus.busy_count !== 3'd0) begin n_fail++; $display("FAIL reset_busy_count: got %0d want 0", bus.busy_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_issue_ready();
        n_checks++; if (bus.issue_tag !== 4'd1) begin n_fail++; $display("FAIL ready_issue_tag: got %0d want 1", bus.issue_tag); end
        issue(4'd3, 32'd5, 4'd0, 32'd7, 4'd0);
        @(negedge clk);
        idle();
        n_checks++; if (bus.disp_valid !== 1'b1) begin n_fail++; $display("FAIL ready_disp_valid: got %b want 1", bus.disp_valid); end
        n_checks++; if ({bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag} !== {4'd3, 32'd5, 32'd7, 4'd1}) begin n_fail++; $display("FAIL ready_disp_fields: got op=%0d vj=%0d vk=%0d tag=%0d want 3 5 7 1", bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag); end
        n_checks++; if (bus.busy_count !== 3'd1) begin n_fail++; $display("FAIL ready_busy_count: got %0d want 1", bus.busy_count); end
        // a tag-0 broadcast must not overwrite the already present operand
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd0; bus.cdb_data = 32'h99;
        @(negedge clk);
        idle();
        n_checks++; if (bus.disp_vj !== 32'd5 || bus.disp_vk !== 32'd7) begin n_fail++; $display("FAIL cdb_tag0_ignored: got vj=%h vk=%h want 5 7", bus.disp_vj, bus.disp_vk); end
        bus.disp_ready = 1'b1;
        @(negedge clk);
        bus.disp_ready = 1'b0;
        n_checks++; if (bus.disp_valid !== 1'b0 || bus.busy_count !== 3'd0) begin n_fail++; $display("FAIL ready_drained: got valid=%b busy=%0d want 0 0", bus.disp_valid, bus.busy_count); end
    endtask

    task automatic test_cdb_capture();
        issue(4'd1, 32'hDEAD, 4'd9, 32'd2, 4'd0);
        @(negedge clk);
        idle();
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL cdb_wait1: got disp_valid %b want 0", bus.disp_valid); end
        @(negedge clk);
        n_checks++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL cdb_wait2: got disp_valid %b want 0", bus.disp_valid); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9; bus.cdb_data = 32'hAB;
        @(negedge clk);
        idle();
        n_checks++; if ({bus.disp_valid, bus.disp_vj, bus.disp_vk, bus.disp_tag} !== {1'b1, 32'hAB, 32'd2, 4'd1}) begin n_fail++; $display("FAIL cdb_capture: got valid=%b vj=%h vk=%h tag=%0d want 1 ab 2 1", bus.disp_valid, bus.disp_vj, bus.disp_vk, bus.disp_tag); end
        bus.disp_ready = 1'b1;
        @(negedge clk);
        bus.disp_ready = 1'b0;
    endtask

    task automatic test_bypass();
        issue(4'd2, 32'd4, 4'd0, 32'hBAD, 4'd6);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd6; bus.cdb_data = 32'h11;
        @(negedge clk);
        idle();
        n_checks++; if ({bus.disp_valid, bus.disp_vj, bus.disp_vk, bus.disp_tag} !== {1'b1, 32'd4, 32'h11, 4'd1}) begin n_fail++; $display("FAIL bypass: got valid=%b vj=%h vk=%h tag=%0d want 1 4 11 1", bus.disp_valid, bus.disp_vj, bus.disp_vk, bus.disp_tag); end
        bus.disp_ready = 1'b1;
        @(negedge clk);
        bus.disp_ready = 1'b0;
        n_checks++; if (bus.busy_count !== 3'd0) begin n_fail++; $display("FAIL bypass_drained: got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_full();
        logic [31:0] exp_vj [4];
        exp_vj = '{32'd11, 32'd12, 32'd13, 32'd99};
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.issue_tag !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_tag%0d: got %0d want %0d", i, bus.issue_tag, i + 1); end
            issue(4'd5, 32'(10 + i), 4'd0, 32'd0, 4'd0);
            @(negedge clk);
        end
        issue(4'd6, 32'd99, 4'd0, 32'd0, 4'd0);
        n_checks++; if (bus.issue_ready !== 1'b0 || bus.busy_count !== 3'd4) begin n_fail++; $display("FAIL full_state: got ready=%b busy=%0d want 0 4", bus.issue_ready, bus.busy_count); end
        n_checks++; if (bus.disp_tag !== 4'd1 || bus.disp_vj !== 32'd10) begin n_fail++; $display("FAIL full_oldest: got tag=%0d vj=%0d want 1 10", bus.disp_tag, bus.disp_vj); end
        @(negedge clk);
        n_checks++; if (bus.busy_count !== 3'd4) begin n_fail++; $display("FAIL full_held: got busy=%0d want 4", bus.busy_count); end
        bus.disp_ready = 1'b1;
        @(negedge clk);
        bus.disp_ready = 1'b0;
        n_checks++; if ({bus.busy_count, bus.issue_ready, bus.issue_tag} !== {3'd3, 1'b1, 4'd1}) begin n_fail++; $display("FAIL full_freed: got busy=%0d ready=%b tag=%0d want 3 1 1", bus.busy_count, bus.issue_ready, bus.issue_tag); end
        @(negedge clk);
        idle();
        n_checks++; if (bus.busy_count !== 3'd4) begin n_fail++; $display("FAIL full_refill: got busy=%0d want 4", bus.busy_count); end
        bus.disp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (bus.disp_vj !== exp_vj[k]) begin n_fail++; $display("FAIL age_order%0d: got vj=%0d want %0d", k, bus.disp_vj, exp_vj[k]); end
            @(negedge clk);
        end
        bus.disp_ready = 1'b0;
        n_checks++; if (bus.busy_count !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_back_to_back();
        issue(4'd1, 32'd1, 4'd0, 32'd0, 4'd0);
        @(negedge clk);
        issue(4'd1, 32'd2, 4'd0, 32'd0, 4'd0);
        bus.disp_ready = 1'b1;
        n_checks++; if (bus.disp_vj !== 32'd1 || bus.issue_tag !== 4'd2) begin n_fail++; $display("FAIL b2b_first: got vj=%0d tag=%0d want 1 2", bus.disp_vj, bus.issue_tag); end
        @(negedge clk);
        idle();
        n_checks++; if ({bus.busy_count, bus.disp_vj, bus.disp_tag, bus.issue_tag} !== {3'd1, 32'd2, 4'd2, 4'd1}) begin n_fail++; $display("FAIL b2b_net: got busy=%0d vj=%0d dtag=%0d itag=%0d want 1 2 2 1", bus.busy_count, bus.disp_vj, bus.disp_tag, bus.issue_tag); end
        @(negedge clk);
        bus.disp_ready = 1'b0;
        n_checks++; if (bus.busy_count !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", bus.busy_count); end
    endtask

    task automatic test_no_preempt();
        issue(4'd1, 32'd0, 4'd5, 32'd0, 4'd0);
        @(negedge clk);
        issue(4'd2, 32'd0, 4'd7, 32'd0, 4'd0);
        @(negedge clk);
        issue(4'd3, 32'h33, 4'd0, 32'd0, 4'd0);
        @(negedge clk);
        idle();
        n_checks++; if (bus.disp_valid !== 1'b1 || bus.disp_tag !== 4'd3) begin n_fail++; $display("FAIL lock_offer: got valid=%b tag=%0d want 1 3", bus.disp_valid, bus.disp_tag); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd7; bus.cdb_data = 32'h77;
        @(negedge clk);
        idle();
        n_checks++; if (bus.disp_tag !== 4'd3 || bus.disp_vj !== 32'h33) begin n_fail++; $display("FAIL lock_hold: got tag=%0d vj=%h want 3 33", bus.disp_tag, bus.disp_vj); end
        bus.disp_ready = 1'b1;
        @(negedge clk);
        bus.disp_ready = 1'b0;
        n_checks++; if (bus.disp_tag !== 4'd2 || bus.disp_vj !== 32'h77) begin n_fail++; $display("FAIL lock_next: got tag=%0d vj=%h want 2 77", bus.disp_tag, bus.disp_vj); end
    endtask

    task automatic test_reset_mid();
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({bus.disp_valid, bus.disp_tag, bus.disp_vj, bus.busy_count, bus.issue_ready, bus.issue_tag} !== {1'b0, 4'd0, 32'd0, 3'd0, 1'b1, 4'd1}) begin n_fail++; $display("FAIL async_reset: got valid=%b dtag=%0d vj=%h busy=%0d ready=%b itag=%0d", bus.disp_valid, bus.disp_tag, bus.disp_vj, bus.busy_count, bus.issue_ready, bus.issue_tag); end
        @(negedge clk);
        rst = 1'b0;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd5; bus.cdb_data = 32'h55;
        @(negedge clk);
        idle();
        @(negedge clk);
        n_checks++; if (bus.disp_valid !== 1'b0 || bus.busy_count !== 3'd0) begin n_fail++; $display("FAIL post_reset_cdb: got valid=%b busy=%0d want 0 0", bus.disp_valid, bus.busy_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_issue_ready();
        test_cdb_capture();
        test_bypass();
        test_full();
        test_back_to_back();
        test_no_preempt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station_bank.md
# reservation_station_bank

Bank of reservation-station entries for one functional unit in the Tomasulo core. It sits directly downstream of the instruction issuer and accepts issued operations carrying operand values or producer tags (Vj/Qj, Vk/Qk). It snoops the common data bus (CDB) to resolve pending tags. It dispatches the oldest operation whose operands are both ready to the functional unit over a valid/ready handshake.

## Interface
- ENTRIES, 4, number of entries (2..8)
- DATA_W, 32, operand width
- TAG_W, 4, tag width; tag 0 (TAG_NONE) means "value present"
- OP_W, 4, opcode width
- TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i (must be nonzero, must fit in TAG_W)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  issuer presents an operation
- issue_ready  out  1  at least one entry free
- issue_op  in  OP_W  opcode
- issue_vj, issue_vk  in  DATA_W  operand values (meaningful when matching q is 0)
- issue_qj, issue_qk  in  TAG_W  producer tags
- issue_tag  out  TAG_W  tag of the entry the next accepted issue will occupy; the issuer writes it to Qi[rd]
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcasting tag
- cdb_data  in  DATA_W  broadcast value
- disp_valid  out  1  an operation is offered to the functional unit
- disp_ready  in  1  functional unit accepts
- disp_op  out  OP_W; disp_vj, disp_vk  out  DATA_W; disp_tag  out  TAG_W  offered operation and its result tag
- busy_count  out  $clog2(ENTRIES+1)  occupied entries

## Operation
- Entry state: busy, op, Vj, Qj, Vk, Qk, plus an age relation. Free entries hold don't-care fields.
- Issue: the operation is accepted when issue_valid && issue_ready. It is written into the lowest-index free entry, whose tag equals issue_tag.
- Issue bypass: if cdb_valid and cdb_tag == issue_qj (nonzero) in the accept cycle, store Vj=cdb_data, Qj=0. Qk is handled the same way.
- CDB capture: every busy entry with Qj == cdb_tag (cdb_valid, cdb_tag != 0) loads Vj=cdb_data and sets Qj=0. Qk is handled the same way. A broadcast with cdb_tag == 0 is ignored.
- Ready entry: busy && Qj==0 && Qk==0, evaluated on registered state.
- Selection: the oldest ready entry, tracked by an ENTRIES×ENTRIES age matrix updated on issue.
- Lock: once disp_valid is high and disp_ready is low, the selected entry and all disp_* outputs hold stable until the handshake completes. An older entry becoming ready does not preempt the locked entry.
- Dispatch: on disp_valid && disp_ready the entry is freed at that edge.
- The state machine is implicit per entry: FREE -> WAITING (any q≠0) or READY -> (selected) OFFERED -> FREE.

## Timing
- Reset values: all entries FREE, age matrix cleared, lock clear. issue_ready=1, issue_tag=TAG_BASE, disp_valid=0, disp_op/vj/vk/tag=0, busy_count=0.
- issue_ready, issue_tag, disp_* and busy_count are combinational from registered state only. There is no path from any input to them.
- Latency: an operation issued ready at edge N gives disp_valid in cycle N+1. A CDB capture at edge N makes the entry eligible in cycle N+1.
- A slot freed by dispatch at edge N is reusable in cycle N+1. There is no same-cycle reuse, so issue_ready ignores the concurrent dispatch.
- Full: issue_ready=0. issue_valid is ignored and the issuer must hold its operation.
- Simultaneous issue, CDB and dispatch in one cycle: all three apply at the same edge, and the busy_count delta is the net of issue and dispatch.
- Asynchronous reset mid-operation discards all entries and any locked offer immediately.

## Structure
- tomasulo_pkg: tag_t, data_t, TAG_NONE=0, the e_functional_unit enum, and an rs_issue_t struct {op, vj, qj, vk, qk}.
- Sub-module rs_entry: one entry's storage, CDB capture, and ready flag, instantiated ENTRIES times.
- The allocator, age matrix, lock and dispatch mux live in the top.

## Test plan
- Reset, then issue op=3, qj=qk=0, vj=5, vk=7 -> issue_tag=1 at accept; next cycle disp_valid=1, disp_vj=5, disp_vk=7, disp_tag=1.
- Issue qj=9 with vj=x; CDB tag 9, data 0xAB two cycles later -> no dispatch before the broadcast, then dispatch with disp_vj=0xAB one cycle after it.
- Issue qk=6 in the same cycle as CDB tag 6, data 0x11 -> entry stored ready with Vk=0x11 and dispatched the next cycle.
- Fill 4 entries with disp_ready=0 -> issue_ready=0, busy_count=4, a 5th issue is held. Pulse disp_ready -> busy_count=3, and issue_ready=1 the following cycle with issue_tag equal to the freed entry's tag.
- Entry 2 (younger) ready and offered with disp_ready=0; older entry 1 then becomes ready via CDB -> disp_tag stays 3 until handshake, then becomes 2.
- Assert rst mid-offer with entries pending -> outputs immediately at reset values; a later CDB broadcast causes no dispatch.
